execute_agu_pipe: RTL

Parametrised execute-stage address generation unit for the load/store path. It accepts memory micro-ops from the register-read stage over a valid/ready handshake and computes the effective address as base + offset. It also derives byte enables, lane-aligns store data and flags misaligned accesses. Results are buffered in a DEPTH-entry queue and presented to the LSU over a second valid/ready handshake.

---
 rtl/lca_agu_pkg.sv | 36 +++
 rtl/agu_addr_calc.sv | 53 +++++
 rtl/execute_agu_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lca_agu_pkg.sv
// Shared types for the execute-stage AGU: access sizes, request and queue-entry layouts.
// Structs are sized for the widest supported configuration; narrower instances zero-extend.
package lca_agu_pkg;

  localparam int unsigned XlenMax = 64;
  localparam int unsigned TagWMax = 16;

  typedef enum logic [1:0] {
    SizeByte  = 2'd0,
    SizeHalf  = 2'd1,
    SizeWord  = 2'd2,
    SizeDword = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [XlenMax-1:0] base;
    logic [XlenMax-1:0] offset;
    logic [XlenMax-1:0] store_data;
    mem_size_e          size;
    logic               is_store;
    logic               is_unsigned;
    logic [TagWMax-1:0] tag;
  } agu_req_t;

  typedef struct packed {
    logic [XlenMax-1:0]   addr;
    logic [XlenMax/8-1:0] byte_en;
    logic [XlenMax-1:0]   store_data;
    mem_size_e            size;
    logic                 is_store;
    logic                 is_unsigned;
    logic [TagWMax-1:0]   tag;
    logic                 misaligned;
  } agu_entry_t;

endpackage

// File: rtl/agu_addr_calc.sv
// Combinational effective-address datapath: add, lane byte enables, store-data lane shift,
// and misalignment detection.
module agu_addr_calc
  import lca_agu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   base_i,
  input  logic [XLEN-1:0]   offset_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  mem_size_e         size_i,
  input  logic              is_store_i,
  output logic [XLEN-1:0]   addr_o,
  output logic [XLEN/8-1:0] byte_en_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic              misaligned_o
);

  localparam int unsigned NumBytes = XLEN / 8;
  localparam int unsigned LoW      = $clog2(NumBytes);

  logic [LoW-1:0]      lo;
  logic [NumBytes-1:0] mask;

  // Carry-out intentionally dropped: wrap-around is a legal address.
  assign addr_o = base_i + offset_i;
  assign lo     = addr_o[LoW-1:0];

  always_comb begin
    mask         = '0;
    misaligned_o = 1'b0;
    unique case (size_i)
      SizeByte: mask = NumBytes'(1);
      SizeHalf: begin
        mask         = NumBytes'(3);
        misaligned_o = addr_o[0];
      end
      SizeWord: begin
        mask         = NumBytes'(15);
        misaligned_o = |addr_o[1:0];
      end
      SizeDword: begin
        mask         = '1;
        misaligned_o = (XLEN == 32) || (|addr_o[2:0]);
      end
      default: ;
    endcase
  end

  assign byte_en_o    = misaligned_o ? '0 : (mask << lo);
  assign store_data_o = is_store_i ? (store_data_i << {lo, 3'b000}) : '0;

endmodule

// File: rtl/execute_agu_pipe.sv
// Execute-stage AGU: computes load/store addresses and buffers results in a DEPTH-entry
// FIFO with valid/ready handshakes on both sides.
module execute_agu_pipe
  import lca_agu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   in_base_i,
  input  logic [XLEN-1:0]   in_offset_i,
  input  logic [XLEN-1:0]   in_store_data_i,
  input  logic [1:0]        in_size_i,
  input  logic              in_is_store_i,
  input  logic              in_unsigned_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_addr_o,
  output logic [XLEN/8-1:0] out_byte_en_o,
  output logic [XLEN-1:0]   out_store_data_o,
  output logic [1:0]        out_size_o,
  output logic              out_is_store_o,
  output logic              out_unsigned_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic              out_misaligned_o
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned NumBytes = XLEN / 8;

  agu_req_t   req;
  agu_entry_t new_entry;
  agu_entry_t head;
  agu_entry_t mem_q [DEPTH];

  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       count_q, count_d;
  logic                push, pop;
  logic [XLEN-1:0]     calc_addr, calc_data;
  logic [NumBytes-1:0] calc_be;
  logic                calc_mis;
  logic                unused_bits;

  always_comb begin
    req             = '0;
    req.base        = XlenMax'(in_base_i);
    req.offset      = XlenMax'(in_offset_i);
    req.store_data  = XlenMax'(in_store_data_i);
    req.size        = mem_size_e'(in_size_i);
    req.is_store    = in_is_store_i;
    req.is_unsigned = in_unsigned_i;
    req.tag         = TagWMax'(in_tag_i);
  end

  agu_addr_calc #(
    .XLEN(XLEN)
  ) u_calc (
    .base_i      (req.base[XLEN-1:0]),
    .offset_i    (req.offset[XLEN-1:0]),
    .store_data_i(req.store_data[XLEN-1:0]),
    .size_i      (req.size),
    .is_store_i  (req.is_store),
    .addr_o      (calc_addr),
    .byte_en_o   (calc_be),
    .store_data_o(calc_data),
    .misaligned_o(calc_mis)
  );

  always_comb begin
    new_entry             = '0;
    new_entry.addr        = XlenMax'(calc_addr);
    new_entry.byte_en     = (XlenMax / 8)'(calc_be);
    new_entry.store_data  = XlenMax'(calc_data);
    new_entry.size        = req.size;
    new_entry.is_store    = req.is_store;
    new_entry.is_unsigned = req.is_unsigned;
    new_entry.tag         = req.tag;
    new_entry.misaligned  = calc_mis;
  end

  // in_ready depends only on registered count, never on out_ready.
  assign in_ready_o  = count_q < (PtrW + 1)'(DEPTH);
  assign out_valid_o = count_q != '0;
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + (PtrW + 1)'(1);
      else if (pop && !push) count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign out_addr_o       = head.addr[XLEN-1:0];
  assign out_byte_en_o    = head.byte_en[NumBytes-1:0];
  assign out_store_data_o = head.store_data[XLEN-1:0];
  assign out_size_o       = head.size;
  assign out_is_store_o   = head.is_store;
  assign out_unsigned_o   = head.is_unsigned;
  assign out_tag_o        = head.tag[TAG_W-1:0];
  assign out_misaligned_o = head.misaligned;

  // Zero-extended struct bits above XLEN/TAG_W are never consumed.
  assign unused_bits = ^{req, head};

endmodule
